// File: rtl/spi_master_pkg.sv
// Shared types and constants for the parametrised SPI master.
// MODE0..MODE3 encode {cpol, cpha}.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    DONE
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer, sclk register and edge counter for spi_master_gen.
// Edge strobes are combinational and fire in the cycle before sclk toggles.
module spi_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned NUM_EDGES = 112,
  localparam int unsigned EW = clog2(NUM_EDGES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 timed,
  input  logic                 toggle,
  output logic                 tick,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 last_edge,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [EW-1:0]        edge_q;
  logic                 edge_stb;

  assign tick       = timed && (cnt_q == '0);
  assign edge_stb   = tick && toggle;
  // edge_q holds the number of edges already produced; the next one is edge_q+1
  assign lead_edge  = edge_stb && !edge_q[0];
  assign trail_edge = edge_stb && edge_q[0];
  assign last_edge  = edge_stb && (edge_q == EW'(NUM_EDGES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      cnt_q  <= '0;
      edge_q <= '0;
      sclk   <= 1'b0;
    end else if (load) begin
      div_q  <= div;
      cnt_q  <= div;
      edge_q <= '0;
      sclk   <= cpol;
    end else begin
      if (timed) cnt_q <= tick ? div_q : cnt_q - 1'b1;
      if (edge_stb) begin
        sclk   <= ~sclk;
        edge_q <= edge_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: {header, data_in} shifted MSB first in any
// CPOL/CPHA mode, one-hot active-low selects, read data returned with a pulse.
module spi_master_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned HDR_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned DIV_WIDTH  = 8,
  localparam int unsigned CS_W      = (clog2(NUM_CS) > 1) ? clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [HDR_WIDTH-1:0]  header,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     ssn,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int unsigned N = HDR_WIDTH + DATA_WIDTH;

  state_t                state_q, state_d;
  logic                  cpha_q;
  logic [N-1:0]          sreg_q;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [NUM_CS-1:0]     ssn_sel;
  logic                  accept, timed, toggle;
  logic                  tick, lead_edge, trail_edge, last_edge;
  logic                  sample, advance;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign timed     = state_q inside {SETUP, SHIFT, HOLD, GAP};
  assign toggle    = state_q inside {SETUP, SHIFT};
  assign busy      = timed;
  assign out_valid = (state_q == DONE);

  assign sample  = cpha_q ? trail_edge : lead_edge;
  assign advance = cpha_q ? lead_edge : (trail_edge && !last_edge);

  // The SETUP tick launches edge 1, so edge k lands at 1+k*h and HOLD/GAP
  // each follow the final edge by h cycles; DONE is the out_valid cycle.
  spi_sclk_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .NUM_EDGES (2 * N)
  ) u_sclk (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .cpol       (cpol),
    .div        (div),
    .timed      (timed),
    .toggle     (toggle),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge),
    .sclk       (sclk)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? SETUP : IDLE;
      SETUP:      if (tick) state_d = SHIFT;
      SHIFT:      if (last_edge) state_d = HOLD;
      HOLD:       if (tick) state_d = GAP;
      GAP:        if (tick) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Out-of-range cs_sel leaves every select high.
  always_comb begin
    ssn_sel = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) ssn_sel[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpha_q   <= 1'b0;
      sreg_q   <= '0;
      shadow_q <= '0;
      data_out <= '0;
      ssn      <= '1;
      mosi     <= 1'b0;
    end else if (accept) begin
      cpha_q <= cpha;
      ssn    <= ssn_sel;
      if (cpha) begin
        sreg_q <= {header, data_in};
        mosi   <= 1'b0;
      end else begin
        sreg_q <= {header, data_in} << 1;
        mosi   <= header[HDR_WIDTH-1];
      end
    end else begin
      if (advance) begin
        mosi   <= sreg_q[N-1];
        sreg_q <= sreg_q << 1;
      end
      if (sample) shadow_q <= DATA_WIDTH'({shadow_q, miso});
      if ((state_q == HOLD) && tick) begin
        ssn  <= '1;
        mosi <= 1'b0;
      end
      if ((state_q == GAP) && tick) data_out <= shadow_q;
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: loopback and mode-matched slave frames,
// start/reset corner cases, out-of-range select and back-to-back frames.
module tb_spi_master_gen;
  import spi_master_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
  logic [7:0]  div = '0;
  logic [1:0]  cs_sel = '0;
  logic [23:0] header = '0;
  logic [31:0] data_in = '0;
  logic        busy, out_valid, sclk, mosi;
  logic [3:0]  ssn;
  logic [31:0] data_out;

  logic        start3 = 1'b0;
  logic        busy3, out_valid3, sclk3, mosi3;
  logic [2:0]  ssn3;
  logic [31:0] data_out3;

  spi_master_gen dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .cpol(cpol), .cpha(cpha),
    .div(div), .cs_sel(cs_sel), .header(header), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .sclk(sclk), .ssn(ssn),
    .mosi(mosi), .miso(miso)
  );

  spi_master_gen #(.NUM_CS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .cpol(1'b0), .cpha(1'b0),
    .div(8'd0), .cs_sel(2'd3), .header(24'hFFFFFF), .data_in(32'h0),
    .data_out(data_out3), .out_valid(out_valid3), .sclk(sclk3), .ssn(ssn3),
    .mosi(mosi3), .miso(1'b1)
  );

  int checks = 0, errors = 0;
  int cyc = 0, nvalid = 0, edges = 0, low_cnt = 0, ssn_bad = 0, stab_err = 0;
  int idx = 0, hi_run = 0, last_hi_run = -1, v3_at = -1, ssn3_bad = 0;
  int inj_start_at = -1, inj_hdr_at = -1;
  logic hold_start = 1'b0, loopback = 1'b1;
  logic s_cpol = 1'b0, s_cpha = 1'b0, s_miso = 1'b0;
  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_sel = 1'b0, sel, lead;
  logic [55:0] s_word = '0, rx = '0;
  logic [3:0]  exp_ssn = 4'hF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe after the edge, run the slave model, apply injections.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) nvalid++;
    if (out_valid3 === 1'b1 && v3_at < 0) v3_at = cyc;
    if (ssn3 !== 3'b111) ssn3_bad++;
    if (sclk !== prev_sclk) edges++;
    if (ssn === 4'hF) hi_run++;
    else begin
      if (ssn === exp_ssn) low_cnt++; else ssn_bad++;
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end
    sel = (ssn !== 4'hF);
    if (sel && !prev_sel) begin
      idx = 0;
      s_miso = 1'b0;
      if (!s_cpha) begin
        s_miso = s_word[55];
        idx = 1;
      end
    end else if (sel && (sclk !== prev_sclk)) begin
      lead = (prev_sclk == s_cpol);
      if (lead != s_cpha) begin
        if (mosi !== prev_mosi) stab_err++;
        rx = {rx[54:0], mosi};
      end else if (idx < 56) begin
        s_miso = s_word[55-idx];
        idx++;
      end
    end
    miso = loopback ? mosi : s_miso;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_sel  = sel;
    start3 = 1'b0;
    if (!hold_start) start = (cyc == inj_start_at);
    if (cyc == inj_hdr_at) header = ~header;
  endtask

  task automatic begin_frame(input logic [1:0] mode, input logic [7:0] d, input logic [1:0] cs,
                             input logic [23:0] h, input logic [31:0] dat);
    {cpol, cpha} = mode;
    {s_cpol, s_cpha} = mode;
    div = d; cs_sel = cs; header = h; data_in = dat;
    exp_ssn = 4'hF;
    exp_ssn[cs] = 1'b0;
    start = 1'b1;
    cyc = 0; nvalid = 0; low_cnt = 0; ssn_bad = 0; stab_err = 0; rx = '0;
    tick();
    edges = 0;
  endtask

  task automatic wait_valid(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at;
    logic [31:0] resp_tab [2];
    logic [1:0]  mode_tab [2];
    resp_tab = '{32'hCAFEF00D, 32'h0BADC0DE};
    mode_tab = '{MODE1, MODE2};

    // Reset state
    tick(); tick();
    check("rst_ctl", {busy, out_valid, sclk, mosi, ssn}, 8'b0000_1111);
    check("rst_data", data_out, 32'h0);
    reset = 1'b0;
    tick();
    check("idle_ctl", {busy, out_valid, sclk, mosi, ssn}, 8'b0000_1111);

    // Mode 0, div 0, loopback; dut3 runs an out-of-range select alongside
    loopback = 1'b1;
    start3 = 1'b1;
    begin_frame(MODE0, 8'd0, 2'd2, 24'h812345, 32'hDEADBEEF);
    check("m0_c1", {busy, sclk, mosi, ssn}, 7'b1_0_1_1011);
    wait_valid(300, at);
    check("m0_valid_cyc", at, 115);
    check("m0_data", data_out, 32'hDEADBEEF);
    check("m0_busy_at_valid", {busy, ssn, sclk}, 6'b0_1111_0);
    check("m0_ssn_low", {ssn_bad, low_cnt}, {32'd0, 32'd113});
    check("m0_edges", edges, 112);
    check("m0_rx", rx, {24'h812345, 32'hDEADBEEF});
    check("cs3_valid_cyc", v3_at, 115);
    check("cs3_data", data_out3, 32'hFFFFFFFF);
    tick();
    check("m0_pulse_one", {out_valid, nvalid[3:0]}, 5'b0_0001);

    // Mode 3, div 3, slave returns a data word
    loopback = 1'b0;
    s_word = {24'h5A5A5A, 32'h12345678};
    begin_frame(MODE3, 8'd3, 2'd1, 24'hC0FFEE, 32'h0F1E2D3C);
    check("m3_c1", {busy, sclk, ssn}, 6'b1_1_1101);
    wait_valid(600, at);
    check("m3_valid_cyc", at, 457);
    check("m3_data", data_out, 32'h12345678);
    check("m3_idle_sclk", sclk, 1'b1);
    check("m3_edges", edges, 112);
    check("m3_ssn_low", {ssn_bad, low_cnt}, {32'd0, 32'd452});
    check("m3_rx", rx, {24'hC0FFEE, 32'h0F1E2D3C});
    check("m3_stable", stab_err, 0);

    // Modes 1 and 2, div 1, mode-matched slave
    for (int m = 0; m < 2; m++) begin
      s_word = {24'hA5A5A5, resp_tab[m]};
      begin_frame(mode_tab[m], 8'd1, 2'd0, 24'h3C3C3C, 32'h89ABCDEF);
      wait_valid(600, at);
      check("m12_valid_cyc", at, 229);
      check("m12_data", data_out, resp_tab[m]);
      check("m12_stable", stab_err, 0);
      check("m12_rx", rx, {24'h3C3C3C, 32'h89ABCDEF});
    end

    // start again at cycle 10, header changed at cycle 20
    loopback = 1'b1;
    inj_start_at = 10;
    inj_hdr_at = 20;
    begin_frame(MODE0, 8'd0, 2'd3, 24'h13579B, 32'h2468ACE0);
    wait_valid(300, at);
    check("busy_valid_cyc", at, 115);
    check("busy_rx", rx, {24'h13579B, 32'h2468ACE0});
    check("busy_data", data_out, 32'h2468ACE0);
    for (int i = 0; i < 20; i++) tick();
    check("busy_one_valid", nvalid, 1);
    inj_start_at = -1;
    inj_hdr_at = -1;

    // Reset at cycle 40 aborts the frame
    begin_frame(MODE0, 8'd0, 2'd0, 24'h0F0F0F, 32'h55AA55AA);
    while (cyc < 40) tick();
    reset = 1'b1;
    tick();
    check("abort_ctl", {busy, out_valid, sclk, mosi, ssn}, 8'b0000_1111);
    check("abort_data", data_out, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 150; i++) tick();
    check("abort_no_valid", nvalid, 0);
    begin_frame(MODE0, 8'd0, 2'd0, 24'h0F0F0F, 32'h55AA55AA);
    wait_valid(300, at);
    check("after_abort_cyc", at, 115);
    check("after_abort_data", data_out, 32'h55AA55AA);

    // start held high: back-to-back frames
    hold_start = 1'b1;
    last_hi_run = -1;
    begin_frame(MODE0, 8'd0, 2'd1, 24'hFEDCBA, 32'h76543210);
    wait_valid(300, at);
    check("b2b_first_cyc", at, 115);
    wait_valid(300, at);
    hold_start = 1'b0;
    start = 1'b0;
    check("b2b_second_cyc", at, 230);
    check("b2b_gap", last_hi_run, 2);
    check("b2b_data", data_out, 32'h76543210);
    tick();
    check("b2b_end", {busy, out_valid}, 2'b00);

    check("cs3_ssn_high", ssn3_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
